// File: rtl/pq_pop_dispatcher.sv
// Pop-side client of the array priority queue: one outstanding pop at a time, returned
// cells buffered in a small FWFT FIFO and streamed out. Optional stats: PQ_DISP_STATS_EN.
module pq_pop_dispatcher #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 3,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           pq_empty_i,
  output logic                           pq_pop_o,
  input  logic                           pq_cell_valid_i,
  input  logic [DATA_WIDTH+ID_WIDTH-1:0] pq_cell_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [DATA_WIDTH+ID_WIDTH-1:0] out_cell_o,
`ifdef PQ_DISP_STATS_EN
  output logic [15:0]                    disp_cnt_o,
`endif
  output logic                           err_o
);

  localparam int CELL_W = DATA_WIDTH + ID_WIDTH;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [CELL_W-1:0] mem_q [BUF_DEPTH];

  logic pop;
  logic push;
  logic pull;
  logic not_empty;

  assign not_empty = (count_q != '0);

  // Issue is gated on the registered count only; a dequeue this cycle frees space next cycle.
  always_comb begin
    pop  = (state_q == ST_IDLE) && !pq_empty_i && (count_q != FULL_CNT) && !rst_i;
    push = (state_q == ST_WAIT) && pq_cell_valid_i;
    pull = not_empty && out_ready_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pop)             state_d = ST_WAIT;
      ST_WAIT: if (pq_cell_valid_i) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // A response with no pop outstanding is dropped and flagged until reset.
  always_comb begin
    err_d = err_q | ((state_q == ST_IDLE) && pq_cell_valid_i);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pull) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pull})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= pq_cell_i;
  end

  assign pq_pop_o    = pop;
  assign out_valid_o = not_empty;
  assign out_cell_o  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign err_o       = err_q;

`ifdef PQ_DISP_STATS_EN
  logic [15:0] disp_cnt_q, disp_cnt_d;

  always_comb begin
    disp_cnt_d = disp_cnt_q;
    if (pull && (disp_cnt_q != 16'hFFFF)) disp_cnt_d = disp_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) disp_cnt_q <= '0;
    else       disp_cnt_q <= disp_cnt_d;
  end

  assign disp_cnt_o = disp_cnt_q;
`endif

endmodule
